mips_cpu_bus_tb_mem_ws: RTL and testbench

- Parametrised Avalon-MM-style slave memory model for the MIPS CPU bus testbench.
- Drives its own waitrequest, with fixed or pseudo-random wait states.
- Byte-addressable little-endian array with byteenable writes, base-address windowing and registered readdata.
- Sits between the CPU's bus master port and the testbench; flags protocol and address errors instead of halting.

---
 rtl/mips_cpu_bus_pkg.sv | 19 +
 rtl/mips_cpu_bus_wait_gen.sv | 39 +++
 rtl/mips_cpu_bus_tb_mem_ws.sv | 133 +++++++++++++
 tb/tb_mips_cpu_bus_tb_mem_ws.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// rtl/mips_cpu_bus_pkg.sv - shared types and helpers for the bus memory model
// Contents: state_t bus FSM states, word/err constants, in_range() window check.
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] ERR_READDATA   = 32'hDEAD_BEEF;

  // True when the whole word starting at addr lies inside [base, base+depth).
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (off < depth) && (off <= depth - 32'(BYTES_PER_WORD));
  endfunction

endpackage

// File: rtl/mips_cpu_bus_wait_gen.sv
// rtl/mips_cpu_bus_wait_gen.sv - wait-state generator, fixed or LFSR-random
// Ports: clk, reset (sync, active-high), advance (step LFSR once),
//        wait_cycles[7:0] (wait target for the request being accepted).
module mips_cpu_bus_wait_gen
  import mips_cpu_bus_pkg::*;
#(
  parameter int          WAIT_MODE   = 0,
  parameter int          WAIT_CYCLES = 1,
  parameter int          MAX_WAIT    = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] wait_cycles
);

  logic [15:0] lfsr;
  logic        feedback;
  logic [7:0]  rnd;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
  assign feedback = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr == 16'h0000) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {feedback, lfsr[15:1]};
    end
  end

  // MAX_WAIT may be 255, so the modulus needs nine bits.
  assign rnd         = 8'({1'b0, lfsr[7:0]} % 9'(MAX_WAIT + 1));
  assign wait_cycles = (WAIT_MODE == 1) ? rnd : 8'(WAIT_CYCLES);

endmodule

// File: rtl/mips_cpu_bus_tb_mem_ws.sv
// rtl/mips_cpu_bus_tb_mem_ws.sv - Avalon-MM-style slave memory with wait states
// Ports: clk, reset (sync, active-high), read, write, byteenable[3:0],
//        addr[31:0], writedata[31:0] from the master; waitrequest,
//        readdata[31:0], err (one-cycle pulse) registered back to it.
module mips_cpu_bus_tb_mem_ws
  import mips_cpu_bus_pkg::*;
#(
  parameter string       RAM_FILE    = "",
  parameter int          DEPTH_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int          WAIT_MODE   = 0,
  parameter int          WAIT_CYCLES = 1,
  parameter int          MAX_WAIT    = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [7:0]  wait_cycles;
  logic        advance;
  logic [31:0] l_addr, l_wd;
  logic [3:0]  l_be;
  logic        l_read, l_write;
  logic        viol;

  logic [31:0] c_addr;
  logic        c_read, c_write;
  logic [AW-1:0] idx;
  logic        bad, changed;
  logic [31:0] word;

  mips_cpu_bus_wait_gen #(
    .WAIT_MODE  (WAIT_MODE),
    .WAIT_CYCLES(WAIT_CYCLES),
    .MAX_WAIT   (MAX_WAIT),
    .LFSR_SEED  (LFSR_SEED)
  ) u_wait_gen (
    .clk        (clk),
    .reset      (reset),
    .advance    (advance),
    .wait_cycles(wait_cycles)
  );

  // In IDLE the request is still on the bus; afterwards the latched copy
  // is authoritative. A zero-wait read must load readdata from the live bus.
  always_comb begin
    c_addr  = (state == IDLE) ? addr  : l_addr;
    c_read  = (state == IDLE) ? read  : l_read;
    c_write = (state == IDLE) ? write : l_write;
    idx     = AW'(c_addr - BASE_ADDR);
    bad     = (c_read && c_write) || (c_addr[1:0] != 2'b00) ||
              !in_range(c_addr, BASE_ADDR, 32'(DEPTH_BYTES));
    changed = (state == WAIT) &&
              ((addr != l_addr) || (read != l_read) ||
               (write != l_write) || (byteenable != l_be));
    word = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      word[8*k +: 8] = mem[idx + AW'(k)];
    end
  end

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (read || write) begin
          advance    = 1'b1;
          state_next = (wait_cycles == 8'd0) ? ACK : WAIT;
        end
      end
      WAIT:    if (cnt <= 8'd1) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      waitrequest <= 1'b1;
      readdata    <= 32'h0;
      err         <= 1'b0;
      viol        <= 1'b0;
    end else begin
      state       <= state_next;
      waitrequest <= (state_next != ACK);
      err         <= (state_next == ACK) && (bad || viol || changed);
      if (state == IDLE && (read || write)) begin
        l_addr  <= addr;
        l_wd    <= writedata;
        l_be    <= byteenable;
        l_read  <= read;
        l_write <= write;
        cnt     <= wait_cycles;
        viol    <= 1'b0;
      end else if (state == WAIT) begin
        cnt <= cnt - 8'd1;
        if (changed) viol <= 1'b1;
      end
      if (state_next == ACK && c_read) begin
        readdata <= bad ? ERR_READDATA : word;
      end
    end
  end

  // Writes land on the edge leaving ACK so a reset during the access
  // (including the ACK cycle itself) drops the write entirely.
  always_ff @(posedge clk) begin
    if (!reset && state == ACK && l_write && !bad) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (l_be[k]) mem[idx + AW'(k)] <= l_wd[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_tb_mem_ws.sv
// tb/tb_mips_cpu_bus_tb_mem_ws.sv - self-checking bench for mips_cpu_bus_tb_mem_ws
module tb_mips_cpu_bus_tb_mem_ws;

  localparam logic [31:0] BASE  = 32'hBFC0_0000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  bus_read = '0, bus_write = '0, bus_wq, bus_err;
  logic [3:0]  bus_be    [3];
  logic [31:0] bus_addr  [3];
  logic [31:0] bus_wd    [3];
  logic [31:0] bus_rdata [3];

  logic [7:0]  mdl [3][DEPTH];
  logic [15:0] lfsr;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_cpu_bus_tb_mem_ws #(.RAM_FILE(""), .DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE),
    .WAIT_MODE(0), .WAIT_CYCLES(2), .MAX_WAIT(3), .LFSR_SEED(16'hACE1)) dut0 (
    .clk(clk), .reset(reset), .read(bus_read[0]), .write(bus_write[0]),
    .byteenable(bus_be[0]), .addr(bus_addr[0]), .writedata(bus_wd[0]),
    .waitrequest(bus_wq[0]), .readdata(bus_rdata[0]), .err(bus_err[0]));

  mips_cpu_bus_tb_mem_ws #(.RAM_FILE(""), .DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE),
    .WAIT_MODE(0), .WAIT_CYCLES(0), .MAX_WAIT(3), .LFSR_SEED(16'hACE1)) dut1 (
    .clk(clk), .reset(reset), .read(bus_read[1]), .write(bus_write[1]),
    .byteenable(bus_be[1]), .addr(bus_addr[1]), .writedata(bus_wd[1]),
    .waitrequest(bus_wq[1]), .readdata(bus_rdata[1]), .err(bus_err[1]));

  mips_cpu_bus_tb_mem_ws #(.RAM_FILE(""), .DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE),
    .WAIT_MODE(1), .WAIT_CYCLES(1), .MAX_WAIT(3), .LFSR_SEED(16'hACE1)) dut2 (
    .clk(clk), .reset(reset), .read(bus_read[2]), .write(bus_write[2]),
    .byteenable(bus_be[2]), .addr(bus_addr[2]), .writedata(bus_wd[2]),
    .waitrequest(bus_wq[2]), .readdata(bus_rdata[2]), .err(bus_err[2]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string s, input int d, input logic [31:0] a);
    return $sformatf("%s d%0d @%h", s, d, a);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] b;
    b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (b << 15);
  endfunction

  function automatic logic [31:0] mdl_word(input int d, input int off);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mdl[d][off + k];
    return w;
  endfunction

  // Called just after a negedge; returns just after a negedge.
  task automatic access(input int d, input bit rd_i, input bit wr_i, input logic [31:0] a,
                        input logic [3:0] be_i, input logic [31:0] wd_i, input bit glitch,
                        output int waits, output logic [31:0] rdv, output logic e,
                        output logic gap_wq, output logic gap_err);
    bit first;
    bus_read[d] = rd_i; bus_write[d] = wr_i; bus_addr[d] = a;
    bus_be[d] = be_i; bus_wd[d] = wd_i;
    waits = 0;
    first = 1'b1;
    do begin
      @(negedge clk);
      if (bus_wq[d]) begin
        waits++;
        if (glitch && first) bus_be[d] = ~bus_be[d];
      end
      first = 1'b0;
    end while (bus_wq[d] && waits < 300);
    rdv = bus_rdata[d];
    e   = bus_err[d];
    bus_read[d] = 1'b0; bus_write[d] = 1'b0;
    @(negedge clk);
    gap_wq  = bus_wq[d];
    gap_err = bus_err[d];
  endtask

  task automatic xfer(input int d, input bit rd_i, input bit wr_i, input logic [31:0] a,
                      input logic [3:0] be_i, input logic [31:0] wd_i, input bit glitch,
                      input int exp_w);
    int waits;
    logic [31:0] rdv, off;
    logic e, gwq, gerr;
    bit bad;
    access(d, rd_i, wr_i, a, be_i, wd_i, glitch, waits, rdv, e, gwq, gerr);
    off = a - BASE;
    bad = (rd_i && wr_i) || (a[1:0] != 2'b00) || (off >= DEPTH) || (off + 3 > DEPTH - 1);
    check_eq(tg("wait", d, a), 32'(waits), 32'(exp_w));
    if (d == 2) check_eq(tg("wait_range", d, a), 32'(waits <= 3), 32'd1);
    check_eq(tg("err", d, a), 32'(e), 32'(bad || glitch));
    if (rd_i) begin
      check_eq(tg("rdata", d, a), rdv, bad ? 32'hDEAD_BEEF : mdl_word(d, int'(off)));
    end else if (!bad) begin
      for (int k = 0; k < 4; k++) if (be_i[k]) mdl[d][int'(off) + k] = wd_i[8*k +: 8];
    end
    check_eq(tg("gap_wq", d, a), 32'(gwq), 32'd1);
    check_eq(tg("gap_err", d, a), 32'(gerr), 32'd0);
  endtask

  initial begin
    int waits;
    logic [31:0] rdv, a, wd;
    logic e, gwq, gerr;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < DEPTH; i++) mdl[d][i] = 8'h00;
      bus_be[d] = 4'h0; bus_addr[d] = BASE; bus_wd[d] = 32'h0;
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("reset_wq d%0d", d), 32'(bus_wq[d]), 32'd1);
      check_eq($sformatf("reset_rdata d%0d", d), bus_rdata[d], 32'h0);
      check_eq($sformatf("reset_err d%0d", d), 32'(bus_err[d]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Bring the words the bench uses to a known zero state.
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++)
        access(d, 1'b0, 1'b1, BASE + 32'(w * 4), 4'hF, 32'h0, 1'b0, waits, rdv, e, gwq, gerr);

    // Fixed two-wait device: data, byte lanes, errors, protocol violation.
    xfer(0, 0, 1, BASE,        4'hF,    32'h7856_3412, 0, 2);
    xfer(0, 1, 0, BASE,        4'hF,    32'h0,         0, 2);
    xfer(0, 0, 1, BASE + 8,    4'b0101, 32'hAABB_CCDD, 0, 2);
    xfer(0, 1, 0, BASE + 8,    4'hF,    32'h0,         0, 2);
    xfer(0, 0, 1, BASE + 8,    4'h0,    32'hFFFF_FFFF, 0, 2);
    xfer(0, 1, 0, BASE + 8,    4'hF,    32'h0,         0, 2);
    xfer(0, 1, 0, BASE + 2,    4'hF,    32'h0,         0, 2);
    xfer(0, 1, 0, BASE + DEPTH, 4'hF,   32'h0,         0, 2);
    xfer(0, 1, 0, BASE - 4,    4'hF,    32'h0,         0, 2);
    xfer(0, 0, 1, BASE + 1,    4'hF,    32'hFFFF_FFFF, 0, 2);
    xfer(0, 1, 1, BASE,        4'hF,    32'hFFFF_FFFF, 0, 2);
    xfer(0, 1, 0, BASE,        4'hF,    32'h0,         0, 2);
    xfer(0, 1, 0, BASE + 8,    4'hF,    32'h0,         1, 2);
    xfer(0, 0, 1, BASE + 16,   4'hF,    32'hCAFE_F00D, 0, 2);

    // Zero-wait device: back-to-back completion and error timing.
    xfer(1, 0, 1, BASE,         4'hF, 32'h0102_0304, 0, 0);
    xfer(1, 0, 1, BASE + 4,     4'hF, 32'hA5A5_5A5A, 0, 0);
    xfer(1, 1, 0, BASE,         4'hF, 32'h0,         0, 0);
    xfer(1, 1, 0, BASE + 4,     4'hF, 32'h0,         0, 0);
    xfer(1, 1, 0, BASE + DEPTH, 4'hF, 32'h0,         0, 0);

    // Reset while a write sits in WAIT: write must be dropped.
    bus_write[0] = 1'b1; bus_addr[0] = BASE + 16; bus_be[0] = 4'hF; bus_wd[0] = 32'h1122_3344;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_wq", 32'(bus_wq[0]), 32'd1);
    check_eq("abort_err", 32'(bus_err[0]), 32'd0);
    check_eq("abort_rdata", bus_rdata[0], 32'h0);
    bus_write[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    xfer(0, 1, 0, BASE + 16, 4'hF, 32'h0, 0, 2);

    // Random-wait device against the LFSR reference.
    lfsr = 16'hACE1;
    for (int i = 0; i < 20; i++) begin
      a  = BASE + 32'($urandom_range(0, 15)) * 4;
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      xfer(2, 0, 1, a, 4'($urandom), wd, 0, int'(lfsr[7:0]) % 4);
      lfsr = lfsr_step(lfsr);
      a = BASE + 32'($urandom_range(0, 15)) * 4;
      xfer(2, 1, 0, a, 4'hF, 32'h0, 0, int'(lfsr[7:0]) % 4);
      lfsr = lfsr_step(lfsr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
